// File: rtl/fwd_datapath.sv
// rtl/fwd_datapath.sv - four-stage IF/ID/EX/WB integer datapath with EX forwarding
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   imem_we/waddr/wdata   loader write port into the instruction memory
//   pc_write              allow the PC to advance by one word
//   stall                 hold PC and IF/ID, push a bubble into ID/EX
//   rf_we, alu_b_sel,     ID-stage control from an external control unit
//   alu_op                (which decodes instr_out)
//   instr_out             IF/ID instruction word
//   pc_out                current fetch PC (byte address)
//   tx_data, tx_valid     WB-stage result and "register write retiring" flag

module fwd_datapath #(
  parameter int DATA_W     = 8,
  parameter int NB_OP      = 6,
  parameter int NREG       = 32,
  parameter int IMEM_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          pc_write,
  input  logic                          stall,
  input  logic                          rf_we,
  input  logic                          alu_b_sel,
  input  logic [NB_OP-1:0]              alu_op,
  output logic [31:0]                   instr_out,
  output logic [31:0]                   pc_out,
  output logic [DATA_W-1:0]             tx_data,
  output logic                          tx_valid
);

  localparam int AW  = $clog2(IMEM_DEPTH);
  localparam int RW  = $clog2(NREG);
  localparam int SHW = $clog2(DATA_W);

  localparam logic [NB_OP-1:0] ALU_ADD = NB_OP'(0);
  localparam logic [NB_OP-1:0] ALU_SUB = NB_OP'(1);
  localparam logic [NB_OP-1:0] ALU_AND = NB_OP'(2);
  localparam logic [NB_OP-1:0] ALU_OR  = NB_OP'(3);
  localparam logic [NB_OP-1:0] ALU_XOR = NB_OP'(4);
  localparam logic [NB_OP-1:0] ALU_SRA = NB_OP'(5);
  localparam logic [NB_OP-1:0] ALU_SRL = NB_OP'(6);
  localparam logic [NB_OP-1:0] ALU_LUI = NB_OP'(7);
  localparam logic [NB_OP-1:0] ALU_SLL = NB_OP'(8);

  // ---------------------------------------------------------------------
  // IF: PC and instruction memory
  // ---------------------------------------------------------------------
  // Only the low AW+2 bits of the PC are kept; the natural overflow of this
  // register gives the wrap modulo 4*IMEM_DEPTH.
  logic [AW+1:0] pc_q;
  logic [31:0]   imem [IMEM_DEPTH];
  logic [31:0]   fetch_word;

  // Not reset: the loaded program must survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  // Asynchronous read sees the pre-edge contents on a same-address write.
  assign fetch_word = imem[pc_q[AW+1:2]];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else if (pc_write && !stall) begin
      pc_q <= pc_q + (AW+2)'(4);
    end
  end

  assign pc_out = 32'(pc_q);

  // ---------------------------------------------------------------------
  // IF/ID
  // ---------------------------------------------------------------------
  logic [31:0] ifid_instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr <= '0;
    end else if (!stall) begin
      ifid_instr <= fetch_word;
    end
  end

  assign instr_out = ifid_instr;

  // ---------------------------------------------------------------------
  // EX/WB state (declared early: it feeds the register file bypass)
  // ---------------------------------------------------------------------
  logic              exwb_rf_we;
  logic [RW-1:0]     exwb_rd;
  logic [DATA_W-1:0] exwb_result;
  logic              wb_write;

  // A write to x0 is never a real write, so it neither updates the register
  // file nor forwards anywhere.
  assign wb_write = exwb_rf_we && (exwb_rd != '0);

  // ---------------------------------------------------------------------
  // ID: field decode and register file
  // ---------------------------------------------------------------------
  logic [RW-1:0]     id_rs1;
  logic [RW-1:0]     id_rs2;
  logic [RW-1:0]     id_rd;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_rs1_val;
  logic [DATA_W-1:0] id_rs2_val;
  logic [DATA_W-1:0] rf [NREG];

  assign id_rs1 = ifid_instr[15 +: RW];
  assign id_rs2 = ifid_instr[20 +: RW];
  assign id_rd  = ifid_instr[7 +: RW];
  // Sign-extend the 12-bit immediate, then fit it to the datapath width.
  assign id_imm = DATA_W'($signed(ifid_instr[31:20]));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_write) begin
      rf[exwb_rd] <= exwb_result;
    end
  end

  // Write-through: the result retiring this cycle is visible to ID now,
  // which covers the distance-2 dependency without an extra forward path.
  always_comb begin
    id_rs1_val = rf[id_rs1];
    if (id_rs1 == '0) begin
      id_rs1_val = '0;
    end else if (wb_write && (exwb_rd == id_rs1)) begin
      id_rs1_val = exwb_result;
    end

    id_rs2_val = rf[id_rs2];
    if (id_rs2 == '0) begin
      id_rs2_val = '0;
    end else if (wb_write && (exwb_rd == id_rs2)) begin
      id_rs2_val = exwb_result;
    end
  end

  // ---------------------------------------------------------------------
  // ID/EX
  // ---------------------------------------------------------------------
  logic              idex_rf_we;
  logic              idex_b_sel;
  logic [NB_OP-1:0]  idex_op;
  logic [RW-1:0]     idex_rd;
  logic [RW-1:0]     idex_rs1;
  logic [RW-1:0]     idex_rs2;
  logic [DATA_W-1:0] idex_a;
  logic [DATA_W-1:0] idex_b;
  logic [DATA_W-1:0] idex_imm;

  // A stall loads an all-zero bubble: no write, rd=0, and operands that
  // cannot match any forwarding source.
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      idex_rf_we <= 1'b0;
      idex_b_sel <= 1'b0;
      idex_op    <= '0;
      idex_rd    <= '0;
      idex_rs1   <= '0;
      idex_rs2   <= '0;
      idex_a     <= '0;
      idex_b     <= '0;
      idex_imm   <= '0;
    end else begin
      idex_rf_we <= rf_we;
      idex_b_sel <= alu_b_sel;
      idex_op    <= alu_op;
      idex_rd    <= id_rd;
      idex_rs1   <= id_rs1;
      idex_rs2   <= id_rs2;
      idex_a     <= id_rs1_val;
      idex_b     <= id_rs2_val;
      idex_imm   <= id_imm;
    end
  end

  // ---------------------------------------------------------------------
  // EX: forwarding and ALU
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] rs2_fwd;
  logic [DATA_W-1:0] op_b;
  logic [SHW-1:0]    shamt;
  logic [DATA_W-1:0] ex_result;

  always_comb begin
    op_a = idex_a;
    if (wb_write && (exwb_rd == idex_rs1)) begin
      op_a = exwb_result;
    end

    // rs2 is only an operand in register form, so only forward it then.
    rs2_fwd = idex_b;
    if (!idex_b_sel && wb_write && (exwb_rd == idex_rs2)) begin
      rs2_fwd = exwb_result;
    end

    op_b = idex_b_sel ? idex_imm : rs2_fwd;
  end

  assign shamt = op_b[SHW-1:0];

  always_comb begin
    ex_result = op_a + op_b;
    case (idex_op)
      ALU_ADD: ex_result = op_a + op_b;
      ALU_SUB: ex_result = op_a - op_b;
      ALU_AND: ex_result = op_a & op_b;
      ALU_OR:  ex_result = op_a | op_b;
      ALU_XOR: ex_result = op_a ^ op_b;
      ALU_SRA: ex_result = DATA_W'($signed(op_a) >>> shamt);
      ALU_SRL: ex_result = op_a >> shamt;
      ALU_LUI: ex_result = idex_imm;
      ALU_SLL: ex_result = op_a << shamt;
      default: ex_result = op_a + op_b;
    endcase
  end

  // ---------------------------------------------------------------------
  // EX/WB
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      exwb_rf_we  <= 1'b0;
      exwb_rd     <= '0;
      exwb_result <= '0;
    end else begin
      exwb_rf_we  <= idex_rf_we;
      exwb_rd     <= idex_rd;
      exwb_result <= ex_result;
    end
  end

  assign tx_data  = exwb_result;
  assign tx_valid = wb_write;

endmodule

// File: tb/tb_fwd_datapath.sv
// tb/tb_fwd_datapath.sv - randomized self-checking bench for fwd_datapath

module tb_fwd_datapath;

  logic        clk;
  logic        reset;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        pc_write;
  logic        stall;

  logic        rf_we8, b_sel8, txv8;
  logic [5:0]  op8;
  logic [31:0] instr8, pc8;
  logic [7:0]  txd8;

  logic        rf_we16, b_sel16, txv16;
  logic [5:0]  op16;
  logic [31:0] instr16, pc16;
  logic [15:0] txd16;

  int total = 0;
  int bad   = 0;

  logic [31:0] prog [64];
  int          prog_len;
  bit          exp_v [2][64];
  longint      exp_d [2][64];
  logic        obs_v [64];
  logic [7:0]  obs_d8 [64];
  logic [15:0] obs_d16 [64];

  fwd_datapath u_dut8 (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .pc_write(pc_write), .stall(stall),
    .rf_we(rf_we8), .alu_b_sel(b_sel8), .alu_op(op8),
    .instr_out(instr8), .pc_out(pc8), .tx_data(txd8), .tx_valid(txv8)
  );

  fwd_datapath #(.DATA_W(16), .NB_OP(6), .NREG(16), .IMEM_DEPTH(256)) u_dut16 (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .pc_write(pc_write), .stall(stall),
    .rf_we(rf_we16), .alu_b_sel(b_sel16), .alu_op(op16),
    .instr_out(instr16), .pc_out(pc16), .tx_data(txd16), .tx_valid(txv16)
  );

  // Bench control unit: op[3:0]=instr[3:0], op[5:4]=instr[13:12],
  // b_sel=instr[4], rf_we=instr[5].
  assign rf_we8  = instr8[5];
  assign b_sel8  = instr8[4];
  assign op8     = {instr8[13:12], instr8[3:0]};
  assign rf_we16 = instr16[5];
  assign b_sel16 = instr16[4];
  assign op16    = {instr16[13:12], instr16[3:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] enc(input int op, input bit bsel, input bit we,
                                      input int rd, input int rs1, input int imm);
    logic [31:0] w;
    w        = '0;
    w[3:0]   = op[3:0];
    w[13:12] = op[5:4];
    w[4]     = bsel;
    w[5]     = we;
    w[11:7]  = rd[4:0];
    w[19:15] = rs1[4:0];
    w[31:20] = imm[11:0];
    return w;
  endfunction

  function automatic longint alu_ref(input int op, input longint a, input longint b,
                                     input longint imm, input int w);
    longint mask, sa;
    int     sh;
    mask = (longint'(1) << w) - 1;
    sh   = int'(b % w);
    sa   = (a >= (longint'(1) << (w - 1))) ? a - (longint'(1) << w) : a;
    case (op)
      1:       return (a - b) & mask;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      5:       return (sa >>> sh) & mask;
      6:       return a >> sh;
      7:       return imm;
      8:       return (a << sh) & mask;
      default: return (a + b) & mask;
    endcase
  endfunction

  // Sequential (unpipelined) interpretation of prog from a zeroed register file.
  task automatic compute_model(input int k, input int w, input int nreg);
    longint      regs [32];
    logic [31:0] word;
    int          op, rd, rs1, rs2, imm;
    longint      mask, a, b, r;
    bit          v;
    mask = (longint'(1) << w) - 1;
    for (int i = 0; i < 32; i++) regs[i] = 0;
    for (int i = 0; i < prog_len; i++) begin
      word = prog[i];
      op   = int'({word[13:12], word[3:0]});
      rd   = int'(word >> 7) & (nreg - 1);
      rs1  = int'(word >> 15) & (nreg - 1);
      rs2  = int'(word >> 20) & (nreg - 1);
      imm  = int'(word[31:20]);
      if (imm >= 2048) imm -= 4096;
      a = regs[rs1];
      b = word[4] ? (longint'(imm) & mask) : regs[rs2];
      r = alu_ref(op, a, b, longint'(imm) & mask, w);
      v = word[5] && (rd != 0);
      if (v) regs[rd] = r;
      exp_v[k][i] = v;
      exp_d[k][i] = r;
    end
  endtask

  task automatic gen_random(input int len);
    int op, rs2;
    prog_len = len;
    for (int i = 0; i < len; i++) begin
      op = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) op += $urandom_range(1, 3) * 16;
      rs2 = $urandom_range(0, 7);
      prog[i] = enc(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                    $urandom_range(0, 7), $urandom_range(0, 7),
                    int'($urandom & 32'hFE0) | rs2);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; pc_write = 1'b0; stall = 1'b0; imem_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog_len + 4 && i < 64; i++) begin
      imem_we    = 1'b1;
      imem_waddr = 8'(i);
      imem_wdata = (i < prog_len) ? prog[i] : 32'h0;
      @(negedge clk);
    end
    imem_we = 1'b0;
  endtask

  // Releases reset, runs prog (optionally with a 2-cycle stall starting in
  // cycle stall_at), checks PC and the retire stream of both instances.
  task automatic run_check(input string name, input int stall_at);
    int  model_pc, nb, idx, k;
    bit  prev_stall, bub;
    compute_model(0, 8, 32);
    compute_model(1, 16, 16);
    nb = (stall_at >= 0) ? 2 : 0;
    @(negedge clk);
    reset = 1'b0; pc_write = 1'b1; stall = 1'b0;
    model_pc = 0; prev_stall = 1'b0;
    total++;
    if (pc8 !== 32'(model_pc)) begin
      bad++; $display("FAIL %s pc_start: got %0h want %0h", name, pc8, model_pc);
    end
    for (int t = 1; t <= prog_len + nb + 2; t++) begin
      @(negedge clk);
      if (!prev_stall) model_pc = (model_pc + 4) % 1024;
      total++;
      if (pc8 !== 32'(model_pc) || pc16 !== 32'(model_pc)) begin
        bad++; $display("FAIL %s pc cycle %0d: got %0h/%0h want %0h", name, t, pc8, pc16, model_pc);
      end
      if (t >= 3) begin
        idx = t - 3;
        bub = (stall_at >= 0) && (idx >= stall_at - 1) && (idx <= stall_at);
        k   = (stall_at >= 0 && idx > stall_at) ? idx - 2 : idx;
        if (bub) begin
          total++;
          if (txv8 !== 1'b0 || txv16 !== 1'b0) begin
            bad++; $display("FAIL %s bubble_valid slot %0d: got %0b/%0b want 0", name, idx, txv8, txv16);
          end
        end else begin
          obs_v[k] = txv8; obs_d8[k] = txd8; obs_d16[k] = txd16;
          total++;
          if (txv8 !== exp_v[0][k] || txd8 !== 8'(exp_d[0][k])) begin
            bad++; $display("FAIL %s retire8 instr %0d: got v=%0b d=%0h want v=%0b d=%0h",
                            name, k, txv8, txd8, exp_v[0][k], 8'(exp_d[0][k]));
          end
          total++;
          if (txv16 !== exp_v[1][k] || txd16 !== 16'(exp_d[1][k])) begin
            bad++; $display("FAIL %s retire16 instr %0d: got v=%0b d=%0h want v=%0b d=%0h",
                            name, k, txv16, txd16, exp_v[1][k], 16'(exp_d[1][k]));
          end
        end
      end
      stall = (stall_at >= 0) && (t >= stall_at) && (t < stall_at + 2);
      prev_stall = stall;
    end
    reset = 1'b1; pc_write = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (pc8 !== 32'h0 || txv8 !== 1'b0 || txd8 !== 8'h0 || instr8 !== 32'h0) begin
      bad++; $display("FAIL reset8: got pc=%0h v=%0b d=%0h i=%0h want all 0", pc8, txv8, txd8, instr8);
    end
    total++;
    if (pc16 !== 32'h0 || txv16 !== 1'b0 || txd16 !== 16'h0 || instr16 !== 32'h0) begin
      bad++; $display("FAIL reset16: got pc=%0h v=%0b d=%0h i=%0h want all 0", pc16, txv16, txd16, instr16);
    end
  endtask

  task automatic test_forward();
    do_reset();
    prog_len = 2;
    prog[0] = enc(0, 1, 1, 1, 0, 5);
    prog[1] = enc(0, 1, 1, 2, 1, 3);
    load_prog();
    run_check("forward", -1);
    total++;
    if (obs_v[0] !== 1'b1 || obs_d8[0] !== 8'd5 || obs_v[1] !== 1'b1 || obs_d8[1] !== 8'd8) begin
      bad++; $display("FAIL forward_const: got %0b/%0d %0b/%0d want 1/5 1/8",
                      obs_v[0], obs_d8[0], obs_v[1], obs_d8[1]);
    end
  endtask

  task automatic test_shifts();
    do_reset();
    prog_len = 4;
    prog[0] = enc(7, 1, 1, 1, 0, 'h080);
    prog[1] = enc(5, 1, 1, 2, 1, 1);
    prog[2] = enc(6, 1, 1, 3, 1, 1);
    prog[3] = enc(8, 1, 1, 4, 1, 1);
    load_prog();
    run_check("shifts", -1);
    total++;
    if (obs_d8[0] !== 8'h80 || obs_d8[1] !== 8'hC0 || obs_d8[2] !== 8'h40 || obs_d8[3] !== 8'h00) begin
      bad++; $display("FAIL shift_const: got %0h %0h %0h %0h want 80 c0 40 0",
                      obs_d8[0], obs_d8[1], obs_d8[2], obs_d8[3]);
    end
  endtask

  task automatic test_x0();
    do_reset();
    prog_len = 3;
    prog[0] = enc(0, 1, 1, 0, 0, 7);
    prog[1] = enc(0, 0, 1, 5, 0, 0);
    prog[2] = enc(3, 0, 1, 6, 0, 0);
    load_prog();
    run_check("x0", -1);
    total++;
    if (obs_v[0] !== 1'b0 || obs_d8[1] !== 8'h0 || obs_d8[2] !== 8'h0 || obs_v[1] !== 1'b1) begin
      bad++; $display("FAIL x0_const: got v0=%0b d1=%0h d2=%0h v1=%0b want 0 0 0 1",
                      obs_v[0], obs_d8[1], obs_d8[2], obs_v[1]);
    end
  endtask

  task automatic test_stall();
    do_reset();
    gen_random(12);
    load_prog();
    run_check("stall", 6);
  endtask

  task automatic test_mid_reset();
    do_reset();
    prog_len = 4;
    prog[0] = enc(0, 1, 1, 1, 1, 5);
    prog[1] = enc(0, 1, 1, 2, 2, 1);
    prog[2] = enc(0, 1, 1, 3, 3, 2);
    prog[3] = enc(0, 0, 1, 4, 1, 2);
    load_prog();
    @(negedge clk);
    reset = 1'b0; pc_write = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (txv8 !== 1'b1 || txd8 !== 8'd5) begin
      bad++; $display("FAIL midreset_pre: got v=%0b d=%0h want 1 5", txv8, txd8);
    end
    reset = 1'b1; pc_write = 1'b0;
    @(negedge clk);
    total++;
    if (pc8 !== 32'h0 || txv8 !== 1'b0 || txd8 !== 8'h0 || instr8 !== 32'h0) begin
      bad++; $display("FAIL midreset_clear: got pc=%0h v=%0b d=%0h i=%0h want 0", pc8, txv8, txd8, instr8);
    end
    run_check("after_reset", -1);
    total++;
    if (obs_d8[0] !== 8'd5 || obs_d8[3] !== 8'd6) begin
      bad++; $display("FAIL midreset_rerun: got %0d %0d want 5 6", obs_d8[0], obs_d8[3]);
    end
  endtask

  task automatic test_imem_rw();
    logic [31:0] old_w, new_w;
    do_reset();
    old_w = enc(0, 1, 0, 1, 0, 'h111);
    new_w = enc(0, 1, 0, 2, 0, 'h222);
    prog_len = 1;
    prog[0] = old_w;
    load_prog();
    reset = 1'b0; pc_write = 1'b0;
    imem_we = 1'b1; imem_waddr = 8'h0; imem_wdata = new_w;
    @(negedge clk);
    imem_we = 1'b0;
    total++;
    if (instr8 !== old_w) begin
      bad++; $display("FAIL imem_same_cycle: got %0h want %0h", instr8, old_w);
    end
    @(negedge clk);
    total++;
    if (instr8 !== new_w) begin
      bad++; $display("FAIL imem_after_write: got %0h want %0h", instr8, new_w);
    end
    reset = 1'b1;
  endtask

  task automatic test_pc_wrap();
    int model_pc;
    bit adv;
    do_reset();
    reset = 1'b0; pc_write = 1'b1; stall = 1'b0;
    model_pc = 0; adv = 1'b1;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      if (adv) model_pc = (model_pc + 4) % 1024;
      total++;
      if (pc8 !== 32'(model_pc) || pc16 !== 32'(model_pc)) begin
        bad++; $display("FAIL pc_wrap cycle %0d: got %0h/%0h want %0h", t, pc8, pc16, model_pc);
      end
      pc_write = ($urandom_range(0, 7) != 0);
      stall    = ($urandom_range(0, 7) == 0);
      adv      = pc_write && !stall;
    end
    reset = 1'b1; pc_write = 1'b0; stall = 1'b0;
  endtask

  task automatic test_wide_arith();
    do_reset();
    prog_len = 4;
    prog[0] = enc(0, 1, 1, 1, 0, 'hFFF);
    prog[1] = enc(6, 1, 1, 1, 1, 1);
    prog[2] = enc(0, 1, 1, 2, 1, 1);
    prog[3] = enc(1, 1, 1, 3, 0, 1);
    load_prog();
    run_check("wide", -1);
    total++;
    if (obs_d16[1] !== 16'h7FFF || obs_d16[2] !== 16'h8000 || obs_d16[3] !== 16'hFFFF) begin
      bad++; $display("FAIL wide_const16: got %0h %0h %0h want 7fff 8000 ffff",
                      obs_d16[1], obs_d16[2], obs_d16[3]);
    end
    total++;
    if (obs_d8[2] !== 8'h80 || obs_d8[3] !== 8'hFF) begin
      bad++; $display("FAIL wide_const8: got %0h %0h want 80 ff", obs_d8[2], obs_d8[3]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      do_reset();
      gen_random(20);
      load_prog();
      run_check("random", (n % 2 == 1) ? int'($urandom_range(2, 15)) : -1);
    end
  endtask

  initial begin
    reset = 1'b1; pc_write = 1'b0; stall = 1'b0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    test_reset();
    test_forward();
    test_shifts();
    test_x0();
    test_wide_arith();
    test_stall();
    test_mid_reset();
    test_imem_rw();
    test_pc_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
